// File: rtl/modmul_rr_scheduler_if.sv
// Requester, response and multiplier-facing channels of modmul_rr_scheduler.
interface modmul_rr_scheduler_if #(
  parameter int DAT_BITS = 256,
  parameter int N_REQ    = 4
);
  logic [N_REQ-1:0]            req_tvalid;
  logic [N_REQ*2*DAT_BITS-1:0] req_tdata;
  logic [N_REQ-1:0]            req_tready;
  logic [N_REQ-1:0]            rsp_tvalid;
  logic [DAT_BITS-1:0]         rsp_tdata;
  logic [N_REQ-1:0]            rsp_tready;
  logic [1:0]                  mul_tvalid;
  logic [2*DAT_BITS-1:0]       mul_tdata;
  logic [1:0]                  mul_tready;
  logic                        mul_res_tvalid;
  logic [DAT_BITS-1:0]         mul_res_tdata;
  logic                        mul_res_tready;

  // Scheduler side: arbitrates requesters and masters the multiplier operand channels.
  modport master (
    input  req_tvalid, req_tdata, rsp_tready, mul_tready, mul_res_tvalid, mul_res_tdata,
    output req_tready, rsp_tvalid, rsp_tdata, mul_tvalid, mul_tdata, mul_res_tready
  );

  modport slave (
    output req_tvalid, req_tdata, rsp_tready, mul_tready, mul_res_tvalid, mul_res_tdata,
    input  req_tready, rsp_tvalid, rsp_tdata, mul_tvalid, mul_tdata, mul_res_tready
  );
endinterface

// File: rtl/modmul_rr_scheduler.sv
// Round-robin scheduler sharing one modular multiplier between N_REQ requesters, with in-order tag
// FIFO for result routing. Define MODMUL_RR_STATS_EN to add stat_issued/stat_stall counters.
module modmul_rr_scheduler #(
  parameter int DAT_BITS     = 256,
  parameter int N_REQ        = 4,
  parameter int MAX_INFLIGHT = 16,
  parameter int TAG_BITS     = $clog2(N_REQ)
) (
  input  logic                            aclk,
  input  logic                            areset,
  modmul_rr_scheduler_if.master           bus,
  output logic [$clog2(MAX_INFLIGHT):0]   inflight,
  output logic                            o_err
`ifdef MODMUL_RR_STATS_EN
  ,
  output logic [N_REQ*32-1:0]             stat_issued,
  output logic [31:0]                     stat_stall
`endif
);

  localparam int PTR_BITS = $clog2(MAX_INFLIGHT);
  localparam int CNT_BITS = PTR_BITS + 1;
  localparam logic [CNT_BITS-1:0] MAX_CNT = CNT_BITS'(MAX_INFLIGHT);
  localparam logic [TAG_BITS-1:0] LAST_REQ = TAG_BITS'(N_REQ - 1);

  logic                slot_valid;
  logic [DAT_BITS-1:0] slot_a, slot_b;
  logic [TAG_BITS-1:0] rr_ptr, grant, head;
  logic                found, slot_free, can_accept, accept;
  logic                nonempty, ret_hs;
  logic [PTR_BITS-1:0] wr_ptr, rd_ptr;
  logic [TAG_BITS-1:0] tag_mem [MAX_INFLIGHT];
  int                  idx;

  assign slot_free  = !slot_valid || (&bus.mul_tready);
  assign can_accept = slot_free && (inflight < MAX_CNT);
  assign accept     = found && can_accept;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    found = 1'b0;
    grant = rr_ptr;
    idx   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && bus.req_tvalid[idx]) begin
        found = 1'b1;
        grant = TAG_BITS'(idx);
      end
    end
  end

  always_comb begin
    bus.req_tready = '0;
    if (accept) bus.req_tready[grant] = 1'b1;
  end

  assign bus.mul_tvalid = {2{slot_valid}};
  assign bus.mul_tdata  = {slot_b, slot_a};

  // Results come back in issue order, so the FIFO head always names the owner of the current result.
  assign nonempty           = (inflight != '0);
  assign head               = tag_mem[rd_ptr];
  assign bus.rsp_tdata      = bus.mul_res_tdata;
  assign bus.mul_res_tready = nonempty ? bus.rsp_tready[head] : 1'b1;
  assign ret_hs             = bus.mul_res_tvalid && bus.mul_res_tready && nonempty;

  always_comb begin
    bus.rsp_tvalid = '0;
    if (bus.mul_res_tvalid && nonempty) bus.rsp_tvalid[head] = 1'b1;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      slot_valid <= 1'b0;
      slot_a     <= '0;
      slot_b     <= '0;
      rr_ptr     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      inflight   <= '0;
      o_err      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of order.
      if (accept) begin
        slot_valid <= 1'b1;
        slot_a     <= bus.req_tdata[int'(grant)*2*DAT_BITS +: DAT_BITS];
        slot_b     <= bus.req_tdata[int'(grant)*2*DAT_BITS + DAT_BITS +: DAT_BITS];
        rr_ptr     <= (grant == LAST_REQ) ? '0 : grant + 1'b1;
        wr_ptr     <= wr_ptr + 1'b1;
      end else if (slot_free) begin
        slot_valid <= 1'b0;
      end
      if (ret_hs) rd_ptr <= rd_ptr + 1'b1;
      case ({accept, ret_hs})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
      if (bus.mul_res_tvalid && !nonempty) o_err <= 1'b1;
    end
  end

  // NOTE: tag storage carries no reset; validity is defined solely by the reset pointers and count.
  always_ff @(posedge aclk) begin
    if (accept) tag_mem[wr_ptr] <= grant;
  end

`ifdef MODMUL_RR_STATS_EN
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else begin
      if (accept)
        stat_issued[int'(grant)*32 +: 32] <= stat_issued[int'(grant)*32 +: 32] + 32'd1;
      if ((|bus.req_tvalid) && !can_accept) stat_stall <= stat_stall + 32'd1;
    end
  end
`else
  // Statistics counters compiled out.
`endif

endmodule

// File: tb/tb_modmul_rr_scheduler.sv
// Directed bench for modmul_rr_scheduler with a latency-6, mod-60000 multiplier model.
module tb_modmul_rr_scheduler;
  localparam int DAT_BITS     = 256;
  localparam int N_REQ        = 4;
  localparam int MAX_INFLIGHT = 16;
  localparam int P            = 60000;
  localparam int LAT          = 6;

  typedef logic [DAT_BITS-1:0] word_t;
  typedef struct {
    word_t v;
    int    rdy;
  } res_t;

  logic       aclk = 1'b0;
  logic       areset;
  logic [4:0] inflight;
  logic       o_err;

  res_t q[$];
  int   cyc, n_vec, n_miss, n_acc;
  int   cnt[N_REQ];
  bit   inj, ok;

  modmul_rr_scheduler_if #(.DAT_BITS(DAT_BITS), .N_REQ(N_REQ)) bus ();

  modmul_rr_scheduler #(
    .DAT_BITS(DAT_BITS), .N_REQ(N_REQ), .MAX_INFLIGHT(MAX_INFLIGHT)
  ) dut (
    .aclk(aclk), .areset(areset), .bus(bus), .inflight(inflight), .o_err(o_err)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input word_t obs, input word_t exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_model();
    if (inj) begin
      bus.mul_res_tvalid = 1'b1;
      bus.mul_res_tdata  = word_t'(77);
    end else if (q.size() > 0 && q[0].rdy <= cyc) begin
      bus.mul_res_tvalid = 1'b1;
      bus.mul_res_tdata  = q[0].v;
    end else begin
      bus.mul_res_tvalid = 1'b0;
      bus.mul_res_tdata  = '0;
    end
  endtask

  // Samples handshakes just before the edge, then advances the multiplier model.
  task automatic tick();
    bit    mhs, rhs, was_inj;
    word_t a, b;
    #1;
    mhs     = (bus.mul_tvalid == 2'b11) && (bus.mul_tready == 2'b11);
    rhs     = bus.mul_res_tvalid && bus.mul_res_tready;
    was_inj = inj;
    a       = bus.mul_tdata[DAT_BITS-1:0];
    b       = bus.mul_tdata[2*DAT_BITS-1:DAT_BITS];
    @(posedge aclk);
    cyc++;
    #1;
    if (rhs && !was_inj && q.size() > 0) void'(q.pop_front());
    if (mhs) q.push_back('{v: (a * b) % P, rdy: cyc + LAT});
    drive_model();
    #1;
  endtask

  task automatic set_req(input int i, input int a, input int b);
    bus.req_tdata[i*2*DAT_BITS +: DAT_BITS]            = word_t'(a);
    bus.req_tdata[i*2*DAT_BITS + DAT_BITS +: DAT_BITS] = word_t'(b);
  endtask

  task automatic do_reset();
    areset         = 1'b1;
    inj            = 1'b0;
    bus.req_tvalid = '0;
    q.delete();
    drive_model();
    tick();
    areset = 1'b0;
    #1;
  endtask

  task automatic wait_rsp(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      if (bus.rsp_tvalid != '0) found = 1'b1;
      else tick();
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 80 && inflight != '0; i++) tick();
    check(tag, word_t'(inflight), word_t'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec = 0; n_miss = 0; cyc = 0; inj = 1'b0;
    areset         = 1'b1;
    bus.req_tvalid = '0;
    bus.req_tdata  = '0;
    bus.rsp_tready = '1;
    bus.mul_tready = 2'b11;
    drive_model();
    #2;
    check("rst_req_tready", word_t'(bus.req_tready), word_t'(0));
    check("rst_rsp_tvalid", word_t'(bus.rsp_tvalid), word_t'(0));
    check("rst_mul_tvalid", word_t'(bus.mul_tvalid), word_t'(0));
    check("rst_inflight", word_t'(inflight), word_t'(0));
    check("rst_o_err", word_t'(o_err), word_t'(0));
    check("rst_res_tready", word_t'(bus.mul_res_tready), word_t'(1));
    tick();
    areset = 1'b0;
    #1;

    // Single op: 3*5 = 15 routed to requester 0
    set_req(0, 3, 5);
    bus.req_tvalid = 4'b0001;
    #1;
    check("single_grant", word_t'(bus.req_tready), word_t'(4'b0001));
    tick();
    bus.req_tvalid = '0;
    #1;
    check("single_issue_valid", word_t'(bus.mul_tvalid), word_t'(2'b11));
    check("single_issue_a", bus.mul_tdata[DAT_BITS-1:0], word_t'(3));
    check("single_issue_b", bus.mul_tdata[2*DAT_BITS-1:DAT_BITS], word_t'(5));
    check("single_inflight", word_t'(inflight), word_t'(1));
    tick();
    check("single_slot_drain", word_t'(bus.mul_tvalid), word_t'(0));
    wait_rsp(20, ok);
    check("single_rsp_seen", word_t'(ok), word_t'(1));
    check("single_rsp_route", word_t'(bus.rsp_tvalid), word_t'(4'b0001));
    check("single_rsp_data", bus.rsp_tdata, word_t'(15));
    tick();
    check("single_inflight_done", word_t'(inflight), word_t'(0));

    // Fairness: all requesters valid, grant order 0,1,2,3,...
    do_reset();
    for (int i = 0; i < N_REQ; i++) begin
      set_req(i, i + 1, 2);
      cnt[i] = 0;
    end
    bus.req_tvalid = '1;
    for (int k = 0; k < 16; k++) begin
      #1;
      check($sformatf("fair_grant%0d", k), word_t'(bus.req_tready), word_t'(4'b0001 << (k % 4)));
      for (int i = 0; i < N_REQ; i++) if (bus.req_tready[i]) cnt[i]++;
      tick();
    end
    bus.req_tvalid = '0;
    for (int i = 0; i < N_REQ; i++) check($sformatf("fair_count%0d", i), word_t'(cnt[i]), word_t'(4));
    drain("fair_drain");

    // Routing: req2 300*300 mod 60000 = 30000, then req1 2*7 = 14
    do_reset();
    set_req(2, 300, 300);
    bus.req_tvalid = 4'b0100;
    #1;
    check("route_grant2", word_t'(bus.req_tready), word_t'(4'b0100));
    tick();
    set_req(1, 2, 7);
    bus.req_tvalid = 4'b0010;
    #1;
    check("route_grant1", word_t'(bus.req_tready), word_t'(4'b0010));
    tick();
    bus.req_tvalid = '0;
    wait_rsp(20, ok);
    check("route_rsp2_seen", word_t'(ok), word_t'(1));
    check("route_rsp2_vld", word_t'(bus.rsp_tvalid), word_t'(4'b0100));
    check("route_rsp2_data", bus.rsp_tdata, word_t'(30000));
    tick();
    wait_rsp(20, ok);
    check("route_rsp1_seen", word_t'(ok), word_t'(1));
    check("route_rsp1_vld", word_t'(bus.rsp_tvalid), word_t'(4'b0010));
    check("route_rsp1_data", bus.rsp_tdata, word_t'(14));
    tick();
    check("route_inflight", word_t'(inflight), word_t'(0));

    // Credit limit: results held back until 16 ops are outstanding
    do_reset();
    for (int i = 0; i < N_REQ; i++) set_req(i, i + 1, 2);
    bus.rsp_tready = '0;
    bus.req_tvalid = '1;
    for (int k = 0; k < 16; k++) tick();
    check("credit_inflight_full", word_t'(inflight), word_t'(16));
    check("credit_ready_off", word_t'(bus.req_tready), word_t'(0));
    tick();
    tick();
    check("credit_ready_held", word_t'(bus.req_tready), word_t'(0));
    check("credit_slot_empty", word_t'(bus.mul_tvalid), word_t'(0));
    bus.rsp_tready = '1;
    #1;
    check("credit_release_rdy", word_t'(bus.mul_res_tready), word_t'(1));
    check("credit_release_vld", word_t'(bus.rsp_tvalid), word_t'(4'b0001));
    check("credit_release_data", bus.rsp_tdata, word_t'(2));
    check("credit_no_bypass", word_t'(bus.req_tready), word_t'(0));
    tick();
    bus.rsp_tready = '0;
    #1;
    check("credit_inflight_15", word_t'(inflight), word_t'(15));
    check("credit_ready_back", word_t'(bus.req_tready), word_t'(4'b0001));
    tick();
    check("credit_refill", word_t'(inflight), word_t'(16));
    bus.req_tvalid = '0;
    bus.rsp_tready = '1;
    drain("credit_drain");

    // Head-of-line: req1 result blocks returns while others keep issuing
    do_reset();
    set_req(1, 4, 6);
    bus.req_tvalid = 4'b0010;
    tick();
    bus.req_tvalid = '0;
    bus.rsp_tready = 4'b1101;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus.mul_res_tvalid) ok = 1'b1;
      else tick();
    end
    check("hol_res_seen", word_t'(ok), word_t'(1));
    check("hol_rsp_vld", word_t'(bus.rsp_tvalid), word_t'(4'b0010));
    check("hol_res_tready", word_t'(bus.mul_res_tready), word_t'(0));
    check("hol_rsp_data", bus.rsp_tdata, word_t'(24));
    tick();
    tick();
    check("hol_rsp_held", word_t'(bus.rsp_tvalid), word_t'(4'b0010));
    check("hol_inflight1", word_t'(inflight), word_t'(1));
    set_req(0, 1, 2);
    set_req(2, 3, 2);
    set_req(3, 4, 2);
    bus.req_tvalid = 4'b1101;
    n_acc = 0;
    for (int k = 0; k < 30; k++) begin
      #1;
      if (bus.req_tready != '0) n_acc++;
      tick();
    end
    check("hol_accepts", word_t'(n_acc), word_t'(15));
    check("hol_inflight_full", word_t'(inflight), word_t'(16));
    check("hol_rsp_still", word_t'(bus.rsp_tvalid), word_t'(4'b0010));
    bus.req_tvalid = '0;
    bus.rsp_tready = '1;
    #1;
    check("hol_release_rdy", word_t'(bus.mul_res_tready), word_t'(1));
    drain("hol_drain");

    // Error: result with empty FIFO sets sticky o_err
    inj = 1'b1;
    drive_model();
    #1;
    check("err_res_tready", word_t'(bus.mul_res_tready), word_t'(1));
    check("err_no_rsp", word_t'(bus.rsp_tvalid), word_t'(0));
    tick();
    inj = 1'b0;
    drive_model();
    #1;
    check("err_set", word_t'(o_err), word_t'(1));
    check("err_no_pop", word_t'(inflight), word_t'(0));
    tick();
    tick();
    check("err_sticky", word_t'(o_err), word_t'(1));

    // Reset mid-stream with 5 ops in flight
    bus.rsp_tready = '0;
    set_req(0, 3, 5);
    bus.req_tvalid = 4'b0001;
    for (int k = 0; k < 5; k++) tick();
    bus.req_tvalid = '0;
    #1;
    check("mid_inflight5", word_t'(inflight), word_t'(5));
    areset = 1'b1;
    #1;
    check("mid_rst_req_tready", word_t'(bus.req_tready), word_t'(0));
    check("mid_rst_rsp_tvalid", word_t'(bus.rsp_tvalid), word_t'(0));
    check("mid_rst_mul_tvalid", word_t'(bus.mul_tvalid), word_t'(0));
    check("mid_rst_inflight", word_t'(inflight), word_t'(0));
    check("mid_rst_o_err", word_t'(o_err), word_t'(0));
    q.delete();
    drive_model();
    tick();
    areset = 1'b0;
    #1;
    tick();
    check("post_rst_inflight", word_t'(inflight), word_t'(0));
    check("post_rst_o_err", word_t'(o_err), word_t'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
